// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: shares one SDRAM controller port between a write-only cell writer and a read-only video fetch.
// Define ARB_ROUND_ROBIN_EN for alternating grants; default is read priority with a bounded read streak.
module sdram_port_arbiter #(
  parameter int ADDR_WIDTH = 23,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_READ_STREAK = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] wr_address,
  input  logic                  wr_request,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [3:0]            wr_mask,
  output logic                  wr_done,
  input  logic [ADDR_WIDTH-1:0] rd_address,
  input  logic                  rd_request,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_done,
  output logic [ADDR_WIDTH-1:0] sd_address,
  output logic                  sd_write,
  output logic [DATA_WIDTH-1:0] sd_data,
  output logic [3:0]            sd_mask,
  output logic                  sd_request,
  input  logic                  sd_done,
  input  logic [DATA_WIDTH-1:0] sd_rd_data
);
  typedef enum logic [1:0] {IDLE, READ_BUSY, WRITE_BUSY} state_t;
  state_t state;
  logic wr_pending, rd_pending;
  logic [ADDR_WIDTH-1:0] wr_addr_q, rd_addr_q;
  logic [DATA_WIDTH-1:0] wr_data_q;
  logic [3:0] wr_mask_q;
  logic wr_fin, rd_fin, any_pending, grant, grant_wr;
  assign wr_fin = state == WRITE_BUSY && sd_done;
  assign rd_fin = state == READ_BUSY && sd_done;
  assign any_pending = wr_pending || rd_pending;
  assign grant = state == IDLE && any_pending;
`ifdef ARB_ROUND_ROBIN_EN
  logic last_wr;
  assign grant_wr = wr_pending && (!rd_pending || !last_wr);
  always_ff @(posedge clk or negedge reset)
    if (!reset) last_wr <= 1'b0;
    else if (grant) last_wr <= grant_wr;
`else
  logic [7:0] streak;
  assign grant_wr = wr_pending && (!rd_pending || streak == 8'(MAX_READ_STREAK));
  always_ff @(posedge clk or negedge reset)
    if (!reset) streak <= '0;
    else if (!wr_pending) streak <= '0;
    else if (grant) streak <= grant_wr ? '0 : streak + {7'd0, streak != 8'(MAX_READ_STREAK)};
`endif
  // A new request on the completing edge re-arms the port: set wins over clear.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      wr_pending <= 1'b0;
      rd_pending <= 1'b0;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      wr_data_q <= '0;
      wr_mask_q <= '0;
      wr_done <= 1'b0;
      rd_done <= 1'b0;
      rd_data <= '0;
      sd_address <= '0;
      sd_write <= 1'b0;
      sd_data <= '0;
      sd_mask <= 4'b0000;
      sd_request <= 1'b0;
    end else begin
      wr_done <= wr_fin;
      rd_done <= rd_fin;
      if (rd_fin) rd_data <= sd_rd_data;
      if (wr_fin) wr_pending <= 1'b0;
      if (rd_fin) rd_pending <= 1'b0;
      if (wr_request && (!wr_pending || wr_fin)) begin
        wr_pending <= 1'b1;
        wr_addr_q <= wr_address;
        wr_data_q <= wr_data;
        wr_mask_q <= wr_mask;
      end
      if (rd_request && (!rd_pending || rd_fin)) begin
        rd_pending <= 1'b1;
        rd_addr_q <= rd_address;
      end
      if (grant) begin
        state <= grant_wr ? WRITE_BUSY : READ_BUSY;
        sd_request <= 1'b1;
        sd_write <= grant_wr;
        sd_address <= grant_wr ? wr_addr_q : rd_addr_q;
        sd_data <= grant_wr ? wr_data_q : '0;
        sd_mask <= grant_wr ? wr_mask_q : 4'b0000;
      end else if (state != IDLE && sd_done) begin
        state <= IDLE;
        sd_request <= 1'b0;
      end
    end
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb_sdram_port_arbiter: directed scenarios plus randomized traffic against a transaction-level arbitration model.
module tb_sdram_port_arbiter;
  localparam int AW = 23;
  localparam int DW = 32;
  localparam int MAX = 8;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [AW-1:0] wr_address, rd_address, sd_address;
  logic [DW-1:0] wr_data, rd_data, sd_data, sd_rd_data;
  logic [3:0] wr_mask, sd_mask;
  logic wr_request, rd_request, wr_done, rd_done, sd_write, sd_request, sd_done;
  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  sdram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_READ_STREAK(MAX)) dut (
    .clk(clk), .reset(reset),
    .wr_address(wr_address), .wr_request(wr_request), .wr_data(wr_data), .wr_mask(wr_mask), .wr_done(wr_done),
    .rd_address(rd_address), .rd_request(rd_request), .rd_data(rd_data), .rd_done(rd_done),
    .sd_address(sd_address), .sd_write(sd_write), .sd_data(sd_data), .sd_mask(sd_mask),
    .sd_request(sd_request), .sd_done(sd_done), .sd_rd_data(sd_rd_data)
  );

  task automatic idle_inputs();
    wr_address = '0; wr_request = 0; wr_data = '0; wr_mask = '0;
    rd_address = '0; rd_request = 0; sd_done = 0; sd_rd_data = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 0;
    repeat (2) @(negedge clk);
    reset = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 0;
    @(negedge clk);
    checks++; if ({sd_request, sd_write, sd_address, sd_data, wr_done, rd_done, rd_data} !== '0)
      $display("FAIL reset_outputs: got %h want 0", {sd_request, sd_write, sd_address, sd_data, wr_done, rd_done, rd_data}); else passes++;
    checks++; if (sd_mask !== 4'b0000) $display("FAIL reset_mask: got %h want 0", sd_mask); else passes++;
    reset = 1;
    @(negedge clk);
    checks++; if (sd_request !== 1'b0) $display("FAIL reset_idle: sd_request %b want 0", sd_request); else passes++;
  endtask

  task automatic test_write();
    do_reset();
    wr_address = 23'h000010; wr_data = 32'hF0000041; wr_mask = 4'hF; wr_request = 1;
    @(negedge clk);
    wr_request = 0; wr_address = '1; wr_data = '0; wr_mask = '0;
    checks++; if (sd_request !== 1'b0) $display("FAIL wr_early: sd_request %b want 0", sd_request); else passes++;
    @(negedge clk);
    checks++; if (sd_request !== 1'b1) $display("FAIL wr_req: sd_request %b want 1", sd_request); else passes++;
    checks++; if (sd_write !== 1'b1) $display("FAIL wr_dir: sd_write %b want 1", sd_write); else passes++;
    checks++; if (sd_address !== 23'h000010) $display("FAIL wr_addr: got %h want 000010", sd_address); else passes++;
    checks++; if (sd_data !== 32'hF0000041) $display("FAIL wr_data: got %h want f0000041", sd_data); else passes++;
    checks++; if (sd_mask !== 4'hF) $display("FAIL wr_mask: got %h want f", sd_mask); else passes++;
    @(negedge clk);
    checks++; if (sd_request !== 1'b1) $display("FAIL wr_hold: sd_request %b want 1", sd_request); else passes++;
    sd_done = 1;
    @(negedge clk);
    sd_done = 0;
    checks++; if (wr_done !== 1'b1) $display("FAIL wr_done: got %b want 1", wr_done); else passes++;
    checks++; if (sd_request !== 1'b0) $display("FAIL wr_release: sd_request %b want 0", sd_request); else passes++;
    checks++; if (rd_done !== 1'b0) $display("FAIL wr_no_rd_done: got %b want 0", rd_done); else passes++;
    @(negedge clk);
    checks++; if (wr_done !== 1'b0) $display("FAIL wr_done_pulse: got %b want 0", wr_done); else passes++;
  endtask

  task automatic test_read();
    do_reset();
    rd_address = 23'h0000A0; rd_request = 1;
    @(negedge clk);
    rd_request = 0; rd_address = '0;
    @(negedge clk);
    checks++; if (sd_request !== 1'b1 || sd_write !== 1'b0) $display("FAIL rd_req: req/write %b%b want 10", sd_request, sd_write); else passes++;
    checks++; if (sd_address !== 23'h0000A0) $display("FAIL rd_addr: got %h want 0000a0", sd_address); else passes++;
    sd_done = 1; sd_rd_data = 32'hDEADBEEF;
    @(negedge clk);
    sd_done = 0; sd_rd_data = 32'h12345678;
    checks++; if (rd_done !== 1'b1) $display("FAIL rd_done: got %b want 1", rd_done); else passes++;
    checks++; if (rd_data !== 32'hDEADBEEF) $display("FAIL rd_data: got %h want deadbeef", rd_data); else passes++;
    repeat (2) @(negedge clk);
    checks++; if (rd_done !== 1'b0) $display("FAIL rd_done_pulse: got %b want 0", rd_done); else passes++;
    checks++; if (rd_data !== 32'hDEADBEEF) $display("FAIL rd_data_held: got %h want deadbeef", rd_data); else passes++;
  endtask

  // Both ports continuously requesting: grant order follows the arbitration policy.
  task automatic test_arbitration();
    int n = 0;
    bit acked = 0;
    bit exp_w;
    do_reset();
    wr_address = 23'h000100; wr_data = 32'h0000AA55; wr_mask = 4'h3; wr_request = 1;
    rd_address = 23'h000200; rd_request = 1;
    for (int cyc = 0; cyc < 400 && n < 20; cyc++) begin
      @(negedge clk);
      sd_done = 0;
      if (!sd_request) acked = 0;
      else if (!acked) begin
`ifdef ARB_ROUND_ROBIN_EN
        exp_w = (n % 2) == 0;
`else
        exp_w = (n % (MAX + 1)) == MAX;
`endif
        checks++; if (sd_write !== exp_w) $display("FAIL arb_grant%0d: sd_write %b want %b", n, sd_write, exp_w); else passes++;
        n++;
        sd_done = 1;
        acked = 1;
      end
    end
    checks++; if (n != 20) $display("FAIL arb_timeout: grants %0d want 20", n); else passes++;
    idle_inputs();
  endtask

  task automatic test_ignore();
    int pulses = 0;
    int regrants = 0;
    do_reset();
    wr_address = 23'h000111; wr_data = 32'hAAAA0001; wr_mask = 4'h5; wr_request = 1;
    @(negedge clk);
    wr_address = 23'h000222; wr_data = 32'hBBBB0002; wr_mask = 4'hA;
    @(negedge clk);
    wr_request = 0;
    checks++; if (sd_request !== 1'b1) $display("FAIL ign_req: sd_request %b want 1", sd_request); else passes++;
    checks++; if (sd_address !== 23'h000111) $display("FAIL ign_addr: got %h want 000111", sd_address); else passes++;
    checks++; if (sd_data !== 32'hAAAA0001) $display("FAIL ign_data: got %h want aaaa0001", sd_data); else passes++;
    checks++; if (sd_mask !== 4'h5) $display("FAIL ign_mask: got %h want 5", sd_mask); else passes++;
    sd_done = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      sd_done = 0;
      pulses += int'(wr_done);
      regrants += int'(sd_request);
    end
    checks++; if (pulses != 1) $display("FAIL ign_done_count: got %0d want 1", pulses); else passes++;
    checks++; if (regrants != 0) $display("FAIL ign_regrant: got %0d want 0", regrants); else passes++;
  endtask

  task automatic test_reset_mid();
    int spurious = 0;
    do_reset();
    rd_address = 23'h000333; rd_request = 1;
    @(negedge clk);
    rd_request = 0;
    @(negedge clk);
    checks++; if (sd_request !== 1'b1) $display("FAIL rm_pre: sd_request %b want 1", sd_request); else passes++;
    #2 reset = 0;
    #1;
    checks++; if ({sd_request, sd_write, sd_address, sd_data, sd_mask, wr_done, rd_done, rd_data} !== '0)
      $display("FAIL rm_async: got %h want 0", {sd_request, sd_write, sd_address, sd_data, sd_mask, wr_done, rd_done, rd_data}); else passes++;
    @(negedge clk);
    reset = 1;
    sd_done = 1; sd_rd_data = 32'hCAFEF00D;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      sd_done = 0;
      spurious += int'(rd_done) + int'(wr_done) + int'(sd_request);
    end
    checks++; if (spurious != 0) $display("FAIL rm_no_done: activity %0d want 0", spurious); else passes++;
    wr_address = 23'h000444; wr_data = 32'h00000044; wr_mask = 4'hC; wr_request = 1;
    @(negedge clk);
    wr_request = 0;
    @(negedge clk);
    checks++; if (sd_request !== 1'b1 || sd_write !== 1'b1 || sd_address !== 23'h000444)
      $display("FAIL rm_next: req/write/addr %b%b %h want 11 000444", sd_request, sd_write, sd_address); else passes++;
    sd_done = 1;
    @(negedge clk);
    sd_done = 0;
    checks++; if (wr_done !== 1'b1) $display("FAIL rm_wr_done: got %b want 1", wr_done); else passes++;
  endtask

  // Random traffic; the model tracks outstanding requests per port and the policy's grant choice.
  task automatic test_random();
    bit wp = 0, rp = 0, wp_d = 0, rp_d = 0, prev_req = 0, busy = 0, last_wr = 0;
    bit exp_w, cur_wr = 0, exp_wd = 0, exp_rd = 0;
    logic [AW-1:0] wa = '0, ra = '0;
    logic [DW-1:0] wd = '0, exp_rdata = '0;
    logic [3:0] wm = '0;
    int streak = 0, lat = 0, grants = 0;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      checks++; if (wr_done !== exp_wd) $display("FAIL rnd_wr_done@%0d: got %b want %b", i, wr_done, exp_wd); else passes++;
      checks++; if (rd_done !== exp_rd) $display("FAIL rnd_rd_done@%0d: got %b want %b", i, rd_done, exp_rd); else passes++;
      if (exp_rd) begin
        checks++; if (rd_data !== exp_rdata) $display("FAIL rnd_rd_data@%0d: got %h want %h", i, rd_data, exp_rdata); else passes++;
      end
      if (exp_wd) wp = 0;
      if (exp_rd) rp = 0;
      exp_wd = 0; exp_rd = 0; sd_done = 0;
      if (!wp_d) streak = 0;
      if (sd_request && !prev_req) begin
`ifdef ARB_ROUND_ROBIN_EN
        exp_w = wp_d && (!rp_d || !last_wr);
`else
        exp_w = wp_d && (!rp_d || streak == MAX);
`endif
        grants++;
        checks++; if (!(wp_d || rp_d)) $display("FAIL rnd_spurious_grant@%0d: granted with nothing pending", i); else passes++;
        checks++; if (sd_write !== exp_w) $display("FAIL rnd_dir@%0d: sd_write %b want %b", i, sd_write, exp_w); else passes++;
        if (exp_w) begin
          checks++; if ({sd_address, sd_data, sd_mask} !== {wa, wd, wm})
            $display("FAIL rnd_wr_payload@%0d: got %h %h %h want %h %h %h", i, sd_address, sd_data, sd_mask, wa, wd, wm); else passes++;
          streak = 0;
        end else begin
          checks++; if (sd_address !== ra) $display("FAIL rnd_rd_addr@%0d: got %h want %h", i, sd_address, ra); else passes++;
          if (wp_d && streak < MAX) streak++;
        end
        last_wr = exp_w;
        cur_wr = exp_w;
        busy = 1;
        lat = $urandom_range(0, 3);
      end
      wp_d = wp; rp_d = rp;
      prev_req = sd_request;
      if (busy) begin
        if (lat == 0) begin
          sd_done = 1;
          sd_rd_data = $urandom;
          exp_rdata = sd_rd_data;
          exp_wd = cur_wr;
          exp_rd = !cur_wr;
          busy = 0;
        end else lat--;
      end
      wr_request = 0; rd_request = 0;
      wr_address = AW'($urandom); wr_data = $urandom; wr_mask = 4'($urandom);
      rd_address = AW'($urandom);
      if (!wp && $urandom_range(0, 3) == 0) begin
        wr_request = 1; wa = wr_address; wd = wr_data; wm = wr_mask; wp = 1;
      end
      if (!rp && $urandom_range(0, 2) == 0) begin
        rd_request = 1; ra = rd_address; rp = 1;
      end
    end
    checks++; if (grants < 100) $display("FAIL rnd_progress: grants %0d want >= 100", grants); else passes++;
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_write();
    test_read();
    test_arbitration();
    test_ignore();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
